// File: rtl/riscv_imm_pkg.sv
// Shared RISC-V immediate definitions: format select,
// per-format immediate bit masks and the encoder buffer entry.
package riscv_imm_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_U = 3'd1,
      IMM_S = 3'd2,
      IMM_B = 3'd3,
      IMM_J = 3'd4
   } imm_src_t;

   // Instruction bits occupied by the immediate, per format
   localparam logic [31:0] MASK_I = 32'hFFF0_0000;
   localparam logic [31:0] MASK_U = 32'hFFFF_F000;
   localparam logic [31:0] MASK_S = 32'hFE00_0F80;
   localparam logic [31:0] MASK_B = 32'hFE00_0F80;
   localparam logic [31:0] MASK_J = 32'hFFFF_F000;

   // Widest word address an entry can carry
   localparam int ENTRY_ADDR_W = 32;

   typedef struct packed {
      logic [31:0]             instr;
      logic [ENTRY_ADDR_W-1:0] addr;
      logic                    err;
   } entry_t;

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate inserter: clears the immediate field of
// the template and fills it. Ports: imm_src, imm, template -> instr, legal.
module imm_pack
   import riscv_imm_pkg::*;
(
   input  logic [2:0]  imm_src,
   input  logic [31:0] imm,
   input  logic [31:0] template,
   output logic [31:0] instr,
   output logic        legal
);

   logic        sx11;
   logic        sx12;
   logic        sx20;
   logic [31:0] mask;
   logic [31:0] field;

   // Upper bits must be a pure sign extension to fit the field
   assign sx11 = (&imm[31:11]) | ~(|imm[31:11]);
   assign sx12 = (&imm[31:12]) | ~(|imm[31:12]);
   assign sx20 = (&imm[31:20]) | ~(|imm[31:20]);

   always_comb begin
      legal = 1'b0;
      mask  = '0;
      field = '0;
      unique case (1'b1)
         (imm_src == IMM_I): begin
            legal = sx11;
            mask  = MASK_I;
            field = {imm[11:0], 20'b0};
         end
         (imm_src == IMM_U): begin
            legal = ~(|imm[11:0]);
            mask  = MASK_U;
            field = {imm[31:12], 12'b0};
         end
         (imm_src == IMM_S): begin
            legal = sx11;
            mask  = MASK_S;
            field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
         end
         (imm_src == IMM_B): begin
            legal = sx12 & ~imm[0];
            mask  = MASK_B;
            field = {imm[12], imm[10:5], 13'b0,
                     imm[4:1], imm[11], 7'b0};
         end
         (imm_src == IMM_J): begin
            legal = sx20 & ~imm[0];
            mask  = MASK_J;
            field = {imm[20], imm[10:1], imm[11],
                     imm[19:12], 12'b0};
         end
         default: begin
            legal = 1'b0;
            mask  = '0;
            field = '0;
         end
      endcase
      // Illegal entries keep the field cleared
      instr = (template & ~mask) | (legal ? field : 32'b0);
   end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder with word-address tagging, output FIFO and error counter.
// Ports: in_* request side, out_* buffered result side, restart, err_count.
module imm_encoder
   import riscv_imm_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int BASE_ADDR  = 0,
   parameter int DEPTH      = 1024,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        imm_src,
   input  logic [31:0]       imm,
   input  logic [31:0]       template,
   input  logic              restart,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic [7:0]        err_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST =
      ADDR_W'(BASE_ADDR + 4 * (DEPTH - 1));

   entry_t            mem_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_q;
   logic [PW-1:0]     rd_q;
   logic [PW:0]       cnt_q;
   logic [PW:0]       cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic [ADDR_W-1:0] cur_addr;
   logic [7:0]        err_q;
   logic [7:0]        err_d;
   logic [31:0]       pk_instr;
   logic              pk_legal;
   logic              full;
   logic              push;
   logic              pop;
   entry_t            new_e;
   entry_t            head;

   imm_pack u_pack (
      .imm_src  (imm_src),
      .imm      (imm),
      .template (template),
      .instr    (pk_instr),
      .legal    (pk_legal)
   );

   assign full      = (cnt_q == (PW+1)'(FIFO_DEPTH));
   assign in_ready  = ~full;
   assign out_valid = (cnt_q != '0);
   assign push      = in_valid & ~full;
   assign pop       = out_valid & out_ready;

   // restart in the accept cycle hands this entry the base address
   assign cur_addr = restart ? BASE : addr_q;

   always_comb begin
      new_e.instr = pk_instr;
      new_e.addr  = ENTRY_ADDR_W'(cur_addr);
      new_e.err   = ~pk_legal;
   end

   always_comb begin
      addr_d = addr_q;
      if (push) begin
         addr_d = (cur_addr == LAST) ? BASE : cur_addr + ADDR_W'(4);
      end else if (restart) begin
         addr_d = BASE;
      end
   end

   always_comb begin
      err_d = err_q;
      if (push && !pk_legal && err_q != 8'hFF) begin
         err_d = err_q + 8'd1;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         addr_q <= BASE;
         err_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= new_e;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) begin
            rd_q <= rd_q + 1'b1;
         end
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
         err_q  <= err_d;
      end
   end

   assign head      = mem_q[rd_q];
   assign out_instr = head.instr;
   assign out_addr  = head.addr[ADDR_W-1:0];
   assign out_err   = head.err;
   assign err_count = err_q;

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
Inverse of the immediate sign-extend path. Takes an instruction template (opcode, register and funct fields already placed) plus a 32-bit immediate and an immediate-format select, and inserts the immediate bits at the RISC-V positions for that format. Each accepted instruction gets a sequential word address and is buffered for the instruction-memory loader and the self-test instruction generator. Both sides use a valid/ready handshake.

Parameters:
ADDR_W, 32, width of out_addr.
BASE_ADDR, 0, first write address; must be word aligned.
DEPTH, 1024, number of words before the address wraps back to BASE_ADDR.
FIFO_DEPTH, 2, output buffer entries; power of two, minimum 2.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  input request.
in_ready  out  1  block can accept; equals !full; no combinational path from out_ready.
imm_src  in  3  format select: 0=I, 1=U, 2=S, 3=B, 4=J, 5-7 illegal.
imm  in  32  immediate value, two's complement.
template  in  32  instruction with immediate bit positions don't-care.
restart  in  1  single-cycle pulse; resets the address counter.
out_valid  out  1  buffer non-empty.
out_ready  in  1  consumer accepts.
out_instr  out  32  encoded instruction.
out_addr  out  ADDR_W  word address assigned at acceptance.
out_err  out  1  immediate was not representable, or imm_src was illegal.
err_count  out  8  count of errors, saturating at 255.

Behaviour:
- Reset (synchronous): buffer emptied; out_valid=0, in_ready=1, out_instr=0, out_addr=0, out_err=0, err_count=0; address counter = BASE_ADDR. A reset mid-stream discards all buffered entries.
- Accept: when in_valid & in_ready at a rising edge, the encoded entry is pushed. out_valid goes high the next cycle if the buffer was empty. Latency is 1 cycle.
- Pop: when out_valid & out_ready at a rising edge. Push and pop in the same cycle are allowed whenever not full; the count is unchanged. When full, in_ready=0, so no push occurs even if a pop happens that cycle. Order is FIFO.
- Outputs are driven from the buffer head and held stable while out_valid & !out_ready.
- Encoding: immediate positions in the template are cleared first, then filled. All other template bits pass through unchanged.
  - I: [31:20]=imm[11:0]. Legal if imm[31:11] are all equal.
  - U: [31:12]=imm[31:12]. Legal if imm[11:0]==0.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Legal if imm[31:11] are all equal.
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. Legal if imm[0]==0 and imm[31:12] are all equal.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. Legal if imm[0]==0 and imm[31:20] are all equal.
- Illegal (range failure or imm_src 5-7): the entry is still pushed with out_err=1. Immediate positions for the selected format are zeroed; for imm_src 5-7 the template passes unchanged. err_count increments at acceptance and saturates at 255.
- Address: an entry takes the counter value; the counter then advances by 4. After the last word (BASE_ADDR+4*(DEPTH-1)) it wraps to BASE_ADDR.
- restart: the counter is set to BASE_ADDR; the buffer and err_count are untouched. If restart and accept happen in the same cycle, the entry gets BASE_ADDR and the counter becomes BASE_ADDR+4.

Decomposition:
- Package riscv_imm_pkg holds:
  - enum imm_src_t (IMM_I=0, IMM_U=1, IMM_S=2, IMM_B=3, IMM_J=4), shared with the sign-extend decode;
  - per-format immediate bit-position mask constants;
  - a struct for the buffer entry {instr, addr, err}.
- Sub-module imm_pack: combinational; inputs imm_src, imm, template; outputs instr and legal. It is reusable by the verification model.
- The top level holds the FIFO, the address counter and the error counter.

Test Plan:
1. I-format: template=0x00000013, imm=0xFFFFF800 -> out_instr=0x80000013, out_err=0, out_addr=BASE_ADDR, out_valid high 1 cycle after acceptance.
2. I out of range: template=0x00000013, imm=0x00000800 -> out_instr=0x00000013, out_err=1, err_count=1. Then 256 further errors -> err_count stays at 255.
3. B-format: template=0x00000063, imm=0xFFFFFFFC -> 0xFE000EE3. J-format: template=0x0000006F, imm=0x00000800 -> 0x0010006F. B with imm=0x3 -> out_err=1.
4. Backpressure: out_ready=0, three back-to-back requests -> two accepted, in_ready=0 from the cycle after the second acceptance. Then release out_ready -> entries emerge in order with addrs BASE_ADDR and BASE_ADDR+4, and the third request is then accepted.
5. Wrap and restart: DEPTH=4, five accepts -> addrs 0x0, 0x4, 0x8, 0xC, 0x0. restart asserted together with an accept -> that entry gets 0x0 and the next gets 0x4.
6. Reset mid-stream: buffer full, assert rst for one cycle -> out_valid=0, in_ready=1, err_count=0 in the following cycle, and the next accept gets BASE_ADDR.
